led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
// PURPOSE
//  Time-multiplexed N-digit hex 7-segment display driver; successor to the single-digit hex decoder.
//  Scans NUM_DIGITS digits round-robin, one anode active at a time, with per-digit blank, decimal
//  point, leading-zero suppression, 8-level brightness and tear-free frame-synchronous value update.
//  Sits between CPU/debug status registers and the board's shared-cathode LED pins.
// PARAMETERS
//  NUM_DIGITS     4     digits scanned (1..8)
//  CLK_DIV        1024  clk cycles per digit slot (>=8, multiple of 8)
//  SEG_ACT_LOW    1     1: seg/dp lit when 0; 0: lit when 1
//  AN_ACT_LOW     1     1: anode enabled when 0; 0: enabled when 1
// PORTS
//  clk         in   1              system clock
//  reset       in   1              synchronous, active-high
//  value       in   4*NUM_DIGITS   hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
//  dp_in       in   NUM_DIGITS     decimal point per digit
//  blank_in    in   NUM_DIGITS     1 = force digit dark
//  lz_en       in   1              leading-zero suppression enable
//  load        in   1              1-cycle strobe: capture value/dp_in/blank_in/lz_en
//  brightness  in   3              0 = 1/8 duty ... 7 = full duty
//  seg         out  7              {g,f,e,d,c,b,a}; bit0 = a, bit6 = g
//  dp          out  1              decimal point
//  an          out  NUM_DIGITS     anode enables, one-hot or all off
//  frame_tick  out  1              1-cycle pulse at each digit NUM_DIGITS-1 -> 0 wrap
// BEHAVIOUR
//  Reset: prescaler=0, digit index=0, pending & display regs=0, pending_valid=0;
//   seg/dp = all unlit, an = all disabled, frame_tick=0 (polarity per parameters).
//  Prescaler counts 0..CLK_DIV-1 and wraps; on wrap, digit index increments, NUM_DIGITS-1 -> 0.
//  On the index wrap to 0, frame_tick=1 for exactly one cycle, registered with the index change.
//  load: inputs copied to pending regs, pending_valid=1. Display regs take pending at frame wrap
//   only, then pending_valid=0. A load in the same cycle as the frame wrap goes to pending
//   and applies at the next wrap.
//  Multiple loads within a frame: last one wins.
//  Segment map, active-high lit, {g..a}: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//   5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001
//   d=1011110 E=1111001 F=1110001. SEG_ACT_LOW inverts seg and dp.
//  Digit dark (seg=dp=unlit) when blank_in[i]=1, or when lz_en=1 and all nibbles j>=i are zero
//   with i>0. Digit 0 is never LZ-suppressed. dp_in still lights dp on an LZ-suppressed digit.
//  Anode for current index enabled while prescaler < (brightness+1)*CLK_DIV/8, else all off.
//  Anodes are also off on prescaler==0 (ghost guard; one cycle per slot).
//  Outputs registered; seg/dp/an reflect index/prescaler with 1-cycle latency and change together.
//  Brightness sampled every cycle (no shadowing); a mid-slot change affects the current slot.
//  Reset asserted mid-scan: all state returns to reset values on the next edge; pending load lost.
// STRUCTURE
//  Package led_pkg: hex->7-seg function (active-high {g..a}), SEG_OFF constant, digit index width
//   as $clog2(NUM_DIGITS) helper.
//  One sub-module: led_hex_to_seg (4-bit in, 7-bit active-high out, combinational), instanced once
//   on the muxed nibble.
//  Top holds prescaler, digit index, pending/display regs, LZ mask logic, duty compare, output regs.
// TESTING (NUM_DIGITS=4, CLK_DIV=8, active-low unless noted)
//  Reset -> an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0; hold 20 cycles, no change.
//  load value=16'h12AF, lz_en=0, brightness=7; after next frame_tick -> digits 0..3 show
//   F(0001110), A(0001000), 2(0100100), 1(1111001); an walks 1110,1101,1011,0111; 8-cycle slots.
//  value=16'h0005, lz_en=1 -> digits 3..1 seg=1111111, digit 0 seg=0010010; with lz_en=0,
//   digits 3..1 seg=1000000.
//  load 16'h1111 mid-frame -> display unchanged until frame_tick, then all digits 1111001;
//   load coincident with the wrap applies one frame later.
//  brightness=3 -> an active 3 cycles per slot (prescaler 1..3, 1-cycle latency);
//   brightness=0 -> an never active (guard covers slot 0).
//  blank_in=4'b0100, dp_in=4'b0001 -> digit 2 dark, dp=0 only in digit 0 slot;
//   reset mid-slot -> reset values next cycle.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the multiplexed hex display driver: the glyph table,
// the dark-segment constant and a sizing helper for the digit index.
package led_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // A single-digit display still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph.
module led_hex_to_seg
    import led_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg7(nib_i);

endmodule

// File: rtl/led_scan_driver.sv
// Round-robin N-digit 7-segment scanner with brightness PWM, leading-zero
// suppression and frame-synchronous (tear-free) display updates.
module led_scan_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 1024,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    input  logic                    load,
    input  logic [2:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [6:0]            SEG_RST = {7{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_RST  = {NUM_DIGITS{AN_ACT_LOW}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         pend_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_blank_q, disp_dp_q, disp_blank_q;
    logic                  pend_lz_q, disp_lz_q, pend_vld_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d, ft_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  slot_end, frame_end;
    logic [3:0]            nib;
    logic                  upper_zero, blank_cur, dp_cur, lz_cur, an_on;
    logic [6:0]            seg_hex, seg_lit;
    logic [31:0]           duty_thr;

    always_comb begin
        slot_end  = (presc_q == PW'(CLK_DIV - 1));
        frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d   = slot_end ? '0 : presc_q + PW'(1);
        idx_d     = idx_q;
        if (frame_end) begin
            idx_d = '0;
        end else if (slot_end) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Walk from the most significant digit down so upper_zero means "this and every higher nibble is 0".
    always_comb begin
        nib        = 4'h0;
        blank_cur  = 1'b0;
        dp_cur     = 1'b0;
        lz_cur     = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib       = disp_val_q[4*i +: 4];
                blank_cur = disp_blank_q[i];
                dp_cur    = disp_dp_q[i];
                lz_cur    = disp_lz_q && upper_zero && (i > 0);
            end
        end
    end

    led_hex_to_seg u_hex (
        .nib_i (nib),
        .seg_o (seg_hex)
    );

    // Prescaler value 0 is always dark so the anode switch never overlaps the old segment pattern.
    always_comb begin
        duty_thr = (32'(brightness) + 32'd1) * 32'(CLK_DIV / 8);
        an_on    = (presc_q != '0) && (32'(presc_q) < duty_thr);
        seg_lit  = (blank_cur || lz_cur) ? SEG_OFF : seg_hex;
        seg_d    = SEG_ACT_LOW ? ~seg_lit : seg_lit;
        dp_d     = SEG_ACT_LOW ? ~(dp_cur && !blank_cur) : (dp_cur && !blank_cur);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = AN_ACT_LOW ? !(an_on && (idx_q == IW'(i))) : (an_on && (idx_q == IW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_lz_q    <= 1'b0;
            pend_vld_q   <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            disp_lz_q    <= 1'b0;
            seg_q        <= SEG_RST;
            dp_q         <= SEG_ACT_LOW;
            an_q         <= AN_RST;
            ft_q         <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            // A load coinciding with the wrap stays pending for the following frame.
            if (load) begin
                pend_val_q   <= value;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
                pend_lz_q    <= lz_en;
                pend_vld_q   <= 1'b1;
            end else if (frame_end) begin
                pend_vld_q   <= 1'b0;
            end
            if (frame_end && pend_vld_q) begin
                disp_val_q   <= pend_val_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
                disp_lz_q    <= pend_lz_q;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            ft_q  <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver (4 digits, 8-cycle slots, active-low pins): glyph
// table vectors, corner sequences and random traffic against a cycle-count model.
module tb_led_scan_driver;

    localparam int N  = 4;
    localparam int CD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    led_scan_driver #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (CD),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .load       (load),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Glyphs lit-high {g..a}, indexed by hex value.
    logic [6:0] segtab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // Model state: cycles since reset, shown and pending display contents.
    int          t = 0;
    logic [15:0] m_dv = 16'h0, m_pv = 16'h0;
    logic [3:0]  m_ddp = 4'h0, m_pdp = 4'h0, m_dbl = 4'h0, m_pbl = 4'h0;
    logic        m_dlz = 1'b0, m_plz = 1'b0, m_pvld = 1'b0;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft;
    logic [3:0]  e_an;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        int p, d;
        logic [3:0] oh;
        logic [6:0] lit;
        logic dark, on;
        @(posedge clk);
        if (reset) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
            t = 0;
            m_dv = '0; m_pv = '0; m_ddp = '0; m_pdp = '0; m_dbl = '0; m_pbl = '0;
            m_dlz = 1'b0; m_plz = 1'b0; m_pvld = 1'b0;
        end else begin
            p    = t % CD;
            d    = (t / CD) % N;
            dark = m_dbl[d] || (m_dlz && d > 0 && (m_dv >> (4 * d)) == 16'h0);
            lit  = dark ? 7'h00 : segtab[m_dv[4*d +: 4]];
            e_seg = ~lit;
            e_dp  = ~(m_ddp[d] && !m_dbl[d]);
            on    = (p != 0) && (p < (int'(brightness) + 1) * CD / 8);
            oh    = 4'b0001 << d;
            e_an  = on ? ~oh : 4'hF;
            e_ft  = (p == CD - 1) && (d == N - 1);
            if (e_ft && m_pvld) begin
                m_dv = m_pv; m_ddp = m_pdp; m_dbl = m_pbl; m_dlz = m_plz; m_pvld = 1'b0;
            end
            if (load) begin
                m_pv = value; m_pdp = dp_in; m_pbl = blank_in; m_plz = lz_en; m_pvld = 1'b1;
            end
            t++;
        end
        @(negedge clk);
        chk("cyc_seg", {25'd0, seg}, {25'd0, e_seg});
        chk("cyc_dp", {31'd0, dp}, {31'd0, e_dp});
        chk("cyc_an", {28'd0, an}, {28'd0, e_an});
        chk("cyc_tick", {31'd0, frame_tick}, {31'd0, e_ft});
        load = 1'b0;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        step();
        while (frame_tick !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("tick_wait", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic put(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        value = v; dp_in = d; blank_in = b; lz_en = lz; load = 1'b1;
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dpv;
        logic [3:0]  bl;
        logic        lz;
        int          digit;
        logic [6:0]  seg_x;
        logic        dp_x;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int cnt;
        logic [3:0] an_x;
        vecs[0]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 0, 7'b0001110, 1'b1};
        vecs[1]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 1, 7'b0001000, 1'b1};
        vecs[2]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2, 7'b0100100, 1'b1};
        vecs[3]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 3, 7'b1111001, 1'b1};
        vecs[4]  = '{16'h0005, 4'h0, 4'h0, 1'b1, 3, 7'b1111111, 1'b1};
        vecs[5]  = '{16'h0005, 4'h0, 4'h0, 1'b1, 1, 7'b1111111, 1'b1};
        vecs[6]  = '{16'h0005, 4'h0, 4'h0, 1'b1, 0, 7'b0010010, 1'b1};
        vecs[7]  = '{16'h0005, 4'h0, 4'h0, 1'b0, 3, 7'b1000000, 1'b1};
        vecs[8]  = '{16'h0005, 4'h0, 4'h0, 1'b0, 1, 7'b1000000, 1'b1};
        vecs[9]  = '{16'h1234, 4'h1, 4'h4, 1'b0, 2, 7'b1111111, 1'b1};
        vecs[10] = '{16'h1234, 4'h1, 4'h4, 1'b0, 0, 7'b0011001, 1'b0};
        vecs[11] = '{16'h1234, 4'h1, 4'h4, 1'b0, 1, 7'b0110000, 1'b1};
        vecs[12] = '{16'h0000, 4'h8, 4'h0, 1'b1, 3, 7'b1111111, 1'b0};
        vecs[13] = '{16'h1111, 4'h0, 4'h0, 1'b0, 2, 7'b1111001, 1'b1};

        repeat (20) step();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            put(vecs[k].v, vecs[k].dpv, vecs[k].bl, vecs[k].lz);
            step();
            wait_tick();
            repeat (vecs[k].digit * CD + 2) step();
            an_x = ~(4'b0001 << vecs[k].digit);
            chk("vec_seg", {25'd0, seg}, {25'd0, vecs[k].seg_x});
            chk("vec_dp", {31'd0, dp}, {31'd0, vecs[k].dp_x});
            chk("vec_an", {28'd0, an}, {28'd0, an_x});
        end

        // Mid-frame load holds until the next frame tick.
        put(16'h0005, 4'h0, 4'h0, 1'b0);
        step();
        wait_tick();
        repeat (3) step();
        put(16'h1111, 4'h0, 4'h0, 1'b0);
        step();
        repeat (6) step();
        chk("mid_hold", {25'd0, seg}, {25'd0, 7'b1000000});
        wait_tick();
        repeat (2) step();
        chk("mid_apply0", {25'd0, seg}, {25'd0, 7'b1111001});
        repeat (3 * CD) step();
        chk("mid_apply3", {25'd0, seg}, {25'd0, 7'b1111001});

        // Load in the wrap cycle lands one frame later.
        wait_tick();
        repeat (N * CD - 1) step();
        put(16'h0008, 4'h0, 4'h0, 1'b0);
        step();
        chk("coin_tick", {31'd0, frame_tick}, 32'd1);
        step();
        chk("coin_old", {25'd0, seg}, {25'd0, 7'b1111001});
        wait_tick();
        step();
        chk("coin_new", {25'd0, seg}, 32'h0);

        // Brightness duty per slot.
        wait_tick();
        brightness = 3'd3;
        cnt = 0;
        repeat (CD) begin step(); if (an != 4'hF) cnt++; end
        chk("bright3", cnt, 32'd3);
        brightness = 3'd0;
        cnt = 0;
        repeat (N * CD) begin step(); if (an != 4'hF) cnt++; end
        chk("bright0", cnt, 32'd0);
        brightness = 3'd7;
        cnt = 0;
        repeat (CD) begin step(); if (an != 4'hF) cnt++; end
        chk("bright7", cnt, 32'd7);

        // Reset mid-slot drops a pending load.
        put(16'h9999, 4'hF, 4'h0, 1'b0);
        step();
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("rstmid_seg", {25'd0, seg}, 32'h7F);
        chk("rstmid_an", {28'd0, an}, 32'hF);
        chk("rstmid_dp", {31'd0, dp}, 32'd1);
        chk("rstmid_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;
        wait_tick();
        step();
        chk("rst_lost", {25'd0, seg}, {25'd0, 7'b1000000});

        repeat (1500) begin
            value    = 16'($urandom) >> $urandom_range(0, 16);
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_en    = 1'($urandom);
            load     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
